// File: rtl/ms_updown_counter_if.sv
// Control/status bundle for ms_updown_counter.
// Optional macro MS_CNT_GRAY_EN adds the q_gray status signal.
interface ms_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             sat;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;
`ifdef MS_CNT_GRAY_EN
  logic [WIDTH-1:0] q_gray;
`endif

  // Bench / upstream side: drives controls, observes count and flags.
  modport master (
    output en, up, ld, d, sat,
`ifdef MS_CNT_GRAY_EN
    input  q_gray,
`endif
    input  q, tc, ovf
  );

  // Counter side: consumes controls, produces count and flags.
  modport slave (
    input  en, up, ld, d, sat,
`ifdef MS_CNT_GRAY_EN
    output q_gray,
`endif
    output q, tc, ovf
  );
endinterface

// File: rtl/ms_updown_counter.sv
// Master-slave up/down counter with load, programmable modulus and
// wrap/saturate modes. The master register captures the next value on the
// rising edge; the slave register presents it on q at the falling edge.
// Optional macro MS_CNT_GRAY_EN adds a Gray-coded copy of q (bus.q_gray).
module ms_updown_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input logic               clk,
  input logic               rst,
  ms_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

  logic [WIDTH-1:0] master_d;
  logic [WIDTH-1:0] master_q;
  logic             ovf_m_d;
  logic             ovf_m_q;
  logic [WIDTH-1:0] cnt_q;
  logic             ovf_q;

  // Next master value from the visible count; load beats counting, and the
  // bound checks run before +1/-1 so the result always fits in WIDTH bits.
  always_comb begin
    master_d = cnt_q;
    ovf_m_d  = 1'b0;
    if (bus.ld) begin
      if (bus.d > MAX) begin
        master_d = MAX;
      end else begin
        master_d = bus.d;
      end
    end else if (bus.en) begin
      if (bus.up) begin
        if (cnt_q < MAX) begin
          master_d = cnt_q + ONE_C;
        end else begin
          ovf_m_d  = 1'b1;
          master_d = bus.sat ? MAX : ZERO_C;
        end
      end else begin
        if (cnt_q > ZERO_C) begin
          master_d = cnt_q - ONE_C;
        end else begin
          ovf_m_d  = 1'b1;
          master_d = bus.sat ? ZERO_C : MAX;
        end
      end
    end else begin
      master_d = cnt_q;
      ovf_m_d  = 1'b0;
    end
  end

  // Master stage: sample controls on the rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      master_q <= RST_VAL;
      ovf_m_q  <= 1'b0;
    end else begin
      master_q <= master_d;
      ovf_m_q  <= ovf_m_d;
    end
  end

  // Slave stage: publish the master value half a cycle later.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= RST_VAL;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= master_q;
      ovf_q <= ovf_m_q;
    end
  end

`ifdef MS_CNT_GRAY_EN
  logic [WIDTH-1:0] gray_q;

  // Gray copy registered with the slave so it shares q's timing.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      gray_q <= RST_VAL ^ (RST_VAL >> 1);
    end else begin
      gray_q <= master_q ^ (master_q >> 1);
    end
  end

  assign bus.q_gray = gray_q;
`endif

  assign bus.q   = cnt_q;
  assign bus.ovf = ovf_q;
  // Terminal count depends on the live direction input, not the sampled one.
  assign bus.tc  = bus.up ? (cnt_q == MAX) : (cnt_q == ZERO_C);

endmodule
